alu_core: RTL
=============

// Module: alu_core
// PURPOSE
//  Execution stage directly upstream of the flag register.
//  Accepts an opcode and two operands through a start/busy/done handshake.
//  Single-cycle ops finish in one clock; the iterative multiply takes several.
//  Drives result, carry and a one-cycle enaf strobe for the flag register's dataa/carry/enaf inputs.
// PARAMETERS
//  MAX_WIDTH  8  operand/result width in bits; must match the flag register instance
// PORTS
//  clk      in   1          system clock, all logic on posedge
//  rst      in   1          synchronous, active-low reset (sampled on posedge clk)
//  start    in   1          request; accepted only while busy=0
//  op       in   3          opcode, latched on accept
//  a        in   MAX_WIDTH  operand A, latched on accept
//  b        in   MAX_WIDTH  operand B, latched on accept
//  cin      in   1          carry in (flag C), latched on accept; used by ROL/ROR only
//  busy     out  1          high from the accept edge until the completion edge
//  done     out  1          one-cycle completion pulse
//  result   out  MAX_WIDTH  result; held until the next completion (feeds dataa)
//  carry    out  1          carry/borrow/overflow; held like result
//  enaf     out  1          flag-update strobe; identical to done
// BEHAVIOUR
//  Reset (rst=0 at posedge) from any state, including mid-op:
//   - busy=0, done=0, enaf=0, result=0, carry=0, FSM->IDLE.
//   - No completion pulse is issued for the aborted op.
//  FSM states:
//   - IDLE: start=1 latches op/a/b/cin. Goes to EXEC for MUL, else to DONE.
//   - EXEC: one iteration per cycle; after MAX_WIDTH iterations -> DONE.
//   - DONE: result/carry written, done=enaf=1 for one cycle, then -> IDLE.
//  Latency (start accepted at edge T):
//   - Single-cycle ops: done at T+1.
//   - MUL: done at T+MAX_WIDTH+1.
//   - busy=1 in every cycle between accept and the completion edge; busy=0 in the done cycle.
//  start while busy=1 is ignored; the request is not queued.
//  start in the done cycle is accepted, so back-to-back single-cycle ops give done on every other cycle.
//  Opcodes:
//   - 000 ADD: {carry,result} = a+b, MAX_WIDTH+1-bit sum.
//   - 001 SUB: result = a-b mod 2^W; carry = borrow = (a<b).
//   - 010 AND, 011 OR, 100 XOR: bitwise; carry = 0.
//   - 101 ROL through carry: result = {a[W-2:0],cin}; carry = a[W-1].
//   - 110 ROR through carry: result = {cin,a[W-1:1]}; carry = a[0].
//   - 111 MUL: unsigned shift-add, 2W-bit product; result = low W bits; carry = |(high W bits).
//  Boundaries:
//   - a=b=0 for all ops: result 0 (the flag register derives Z).
//   - Operand changes after accept have no effect.
// CONFIGURATION
//  ALU_MUL_EN defined: MUL implemented as above (multi-cycle via EXEC).
//  ALU_MUL_EN undefined:
//   - EXEC state and multiplier are not built.
//   - Opcode 111 completes in one cycle with result=0, carry=0, enaf still pulsed.
// STRUCTURE
//  Package alu_pkg:
//   - opcode localparams OP_ADD..OP_MUL.
//   - FSM state encodings S_IDLE/S_EXEC/S_DONE.
//  Sub-module alu_mul_iter (present only under ALU_MUL_EN):
//   - load/step interface; owns the product register and iteration counter.
//   - asserts last on the final step.
//  alu_core holds the FSM, operand latches, the single-cycle datapath and the output registers.
// TESTING
//  ADD a=0xFF b=0x01 start@T -> done/enaf@T+1, result=0x00, carry=1, busy high only T..T+1.
//  SUB a=0x03 b=0x05 -> result=0xFE, carry=1.
//  SUB a=0x05 b=0x05 -> result=0x00, carry=0.
//  ROR a=0x02 cin=1 -> result=0x81, carry=0.
//  ROL a=0x80 cin=0 -> result=0x00, carry=1.
//  MUL a=0x10 b=0x10 start@T -> busy T..T+9, done@T+9, result=0x00, carry=1.
//   - start pulse at T+3 with ADD is ignored; no extra done.
//  MUL 0x0F*0x03 with rst=0 at T+4 -> busy/done/result/carry all 0 at T+5, no done pulse.
//   - A new ADD 0x01+0x01 then gives result 0x02 at accept+1.
//  Build without ALU_MUL_EN: op=111 a=0x12 b=0x34 -> done@T+1, result=0x00, carry=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encodings shared by the ALU slice
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_ROR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
endpackage

// File: rtl/alu_if.sv
// alu_if: start/busy/done request bus and flag-register outputs of the ALU
interface alu_if #(parameter int MAX_WIDTH = 8);
  logic                 start;
  logic [2:0]           op;
  logic [MAX_WIDTH-1:0] a;
  logic [MAX_WIDTH-1:0] b;
  logic                 cin;
  logic                 busy;
  logic                 done;
  logic [MAX_WIDTH-1:0] result;
  logic                 carry;
  logic                 enaf;
  modport master (output start, op, a, b, cin, input busy, done, result, carry, enaf);
  modport slave  (input start, op, a, b, cin, output busy, done, result, carry, enaf);
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per step
module alu_mul_iter #(parameter int MAX_WIDTH = 8) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   step,
  input  logic [MAX_WIDTH-1:0]   a,
  input  logic [MAX_WIDTH-1:0]   b,
  output logic [2*MAX_WIDTH-1:0] prod,
  output logic                   last
);
  localparam int CW = $clog2(MAX_WIDTH + 1);
  logic [MAX_WIDTH-1:0] mcand;
  logic [CW-1:0]        cnt;
  logic [MAX_WIDTH:0]   sum;
  // multiplier bits sit in the low half and shift out as the product shifts in
  assign sum  = {1'b0, prod[2*MAX_WIDTH-1:MAX_WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign last = step && cnt == CW'(MAX_WIDTH - 1);
  always_ff @(posedge clk)
    if (!rst) begin
      prod  <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (load) begin
      prod  <= {{MAX_WIDTH{1'b0}}, b};
      mcand <= a;
      cnt   <= '0;
    end else if (step) begin
      prod <= {sum, prod[MAX_WIDTH-1:1]};
      cnt  <= cnt + 1'b1;
    end
endmodule

// File: rtl/alu_core.sv
// alu_core: handshake ALU feeding the flag register; ALU_MUL_EN builds the iterative MUL
module alu_core
  import alu_pkg::*;
#(parameter int MAX_WIDTH = 8) (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);
  state_t               state;
  logic [2:0]           op_q;
  logic [MAX_WIDTH-1:0] a_q, b_q, result;
  logic                 cin_q, busy, done, carry;
  logic [MAX_WIDTH:0]   alu, mul_res;
`ifdef ALU_MUL_EN
  logic [2*MAX_WIDTH-1:0] prod;
  logic                   last;
  alu_mul_iter #(.MAX_WIDTH(MAX_WIDTH)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (state == S_IDLE && bus.start && bus.op == OP_MUL),
    .step (state == S_EXEC),
    .a    (bus.a),
    .b    (bus.b),
    .prod (prod),
    .last (last)
  );
  assign mul_res = {|prod[2*MAX_WIDTH-1:MAX_WIDTH], prod[MAX_WIDTH-1:0]};
`else
  assign mul_res = '0;
`endif
  // bit MAX_WIDTH of alu is the carry/borrow that goes to the flag register
  assign alu = op_q == OP_ADD ? {1'b0, a_q} + {1'b0, b_q}
             : op_q == OP_SUB ? {a_q < b_q, a_q - b_q}
             : op_q == OP_AND ? {1'b0, a_q & b_q}
             : op_q == OP_OR  ? {1'b0, a_q | b_q}
             : op_q == OP_XOR ? {1'b0, a_q ^ b_q}
             : op_q == OP_ROL ? {a_q, cin_q}
             : op_q == OP_ROR ? {a_q[0], cin_q, a_q[MAX_WIDTH-1:1]}
             : mul_res;
  always_ff @(posedge clk)
    if (!rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          op_q  <= bus.op;
          a_q   <= bus.a;
          b_q   <= bus.b;
          cin_q <= bus.cin;
          busy  <= 1'b1;
`ifdef ALU_MUL_EN
          state <= bus.op == OP_MUL ? S_EXEC : S_DONE;
`else
          state <= S_DONE;
`endif
        end
`ifdef ALU_MUL_EN
        S_EXEC: if (last) state <= S_DONE;
`endif
        S_DONE: begin
          result <= alu[MAX_WIDTH-1:0];
          carry  <= alu[MAX_WIDTH];
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.enaf   = done;
  assign bus.result = result;
  assign bus.carry  = carry;
endmodule
